eq_mix_core: RTL and testbench
==============================

EQ_MIX_CORE -- requirements
Module: eq_mix_core

Interface
REQ-001 The block SHALL have parameter NUM_BANDS, default 5, number of equalizer bands per channel (2..16).
REQ-002 The block SHALL have parameter DW, default 16, signed audio sample width.
REQ-003 The block SHALL have parameter PW, default 12, unsigned pot width.
REQ-004 The block SHALL have parameter WARMUP, default 1024, accepted samples required before AMP_ON asserts.
REQ-005 The block SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-007 The block SHALL have port smpl_vld, input, 1, one-cycle strobe meaning the band inputs hold a new sample set.
REQ-008 The block SHALL have ports band_L and band_R, input, NUM_BANDS*DW, packed signed filtered samples, band 0 in the LSBs.
REQ-009 The block SHALL have port pot_band, input, NUM_BANDS*PW, packed unsigned band gains, band 0 in the LSBs.
REQ-010 The block SHALL have port pot_vol, input, PW, unsigned master volume.
REQ-011 The block SHALL have port seq_ok, input, 1, meaning all upstream buffers are sequencing.
REQ-012 The block SHALL have ports lft_out and rht_out, output, DW, signed mixed audio.
REQ-013 The block SHALL have port out_vld, output, 1, one-cycle strobe meaning new lft_out/rht_out.
REQ-014 The block SHALL have ports busy, output, 1, FSM not IDLE; overrun, output, 1, sticky flag for a dropped smpl_vld; sat, output, 1, sticky clip flag.
REQ-015 The block SHALL have port AMP_ON, output, 1, amplifier enable.

Function
REQ-016 The FSM SHALL have states IDLE, MAC and VOL, and SHALL move IDLE->MAC on smpl_vld, MAC->VOL after the band index reaches NUM_BANDS-1, and VOL->IDLE unconditionally.
REQ-017 On accepting smpl_vld in IDLE, the block SHALL register band_L, band_R, pot_band and pot_vol, clear both accumulators, and set the band index to 0.
REQ-018 Each MAC cycle SHALL add (band_x[idx] * {1'b0,pot_band[idx]}) >>> (PW-1) to the L and R accumulators, using one multiplier per channel; pot 2^(PW-1) is unity gain.
REQ-019 Accumulators SHALL be DW+PW+clog2(NUM_BANDS)+1 bits wide and SHALL never overflow internally.
REQ-020 In VOL, each accumulator SHALL be reduced to DW bits (REQ-031/032), multiplied by {1'b0,pot_vol}, shifted >>> PW, and registered to lft_out/rht_out; out_vld SHALL pulse in the following cycle.
REQ-021 Latency SHALL be fixed: out_vld asserts exactly NUM_BANDS+2 cycles after the cycle in which smpl_vld is sampled high in IDLE.
REQ-022 lft_out/rht_out SHALL hold their value between out_vld pulses.
REQ-023 smpl_vld while busy SHALL be ignored, SHALL NOT disturb the in-flight computation, and SHALL set overrun.
REQ-024 The warm-up counter SHALL increment on each accepted smpl_vld while seq_ok=1, saturating at WARMUP; AMP_ON SHALL be 1 when the counter equals WARMUP.
REQ-025 seq_ok=0 SHALL clear the warm-up counter, with AMP_ON falling the next cycle; the in-flight mix is unaffected.
REQ-026 smpl_vld coinciding with the VOL->IDLE cycle SHALL be treated as an overrun (busy is still 1).

Reset
REQ-027 rst=1 SHALL force state IDLE, index 0, accumulators 0, lft_out=rht_out=0, out_vld=0, busy=0, overrun=0, sat=0, warm-up counter 0, AMP_ON=0.
REQ-028 rst asserted mid-MAC or mid-VOL SHALL abort the computation with no out_vld pulse.
REQ-029 Only rst SHALL clear the sticky flags overrun and sat.

Configuration
REQ-030 The macro EQ_MIX_SAT_EN SHALL select the accumulator-to-DW reduction behaviour.
REQ-031 With EQ_MIX_SAT_EN defined, the reduction SHALL clamp to [-2^(DW-1), 2^(DW-1)-1] and set sat when clamping occurs.
REQ-032 Without EQ_MIX_SAT_EN, the reduction SHALL keep the low DW bits (wrap) and sat SHALL be tied to 0.

Verification (NUM_BANDS=5, DW=16, PW=12)
REQ-033 Unity: all bands 0x0100 L/R, pots 0x800, pot_vol 0x800 -> lft_out=rht_out=0x0280, out_vld exactly 7 cycles after smpl_vld.
REQ-034 Clip (SAT_EN): bands 0x7000 L / 0x9000 R, pots 0xFFF, pot_vol 0xFFF -> lft_out=0x7FF7, rht_out=0x8008, sat=1.
REQ-035 Overrun: second smpl_vld 2 cycles after the first -> one out_vld only, first sample's result, overrun=1 until rst.
REQ-036 Warm-up (WARMUP=4): seq_ok=1, 4 spaced smpl_vld -> AMP_ON=1 the cycle after the 4th accept; seq_ok=0 -> AMP_ON=0 next cycle.
REQ-037 Reset mid-MAC: rst 3 cycles after smpl_vld -> no out_vld, outputs 0, busy=0; a new sample then completes normally.
REQ-038 Zero pot: band 2 pot 0, others unity, band 2 = 0x7FFF, others 0 -> outputs 0.

Source files
------------

// File: rtl/eq_mix_core.sv
// rtl/eq_mix_core.sv - per-band gain MAC, master volume and amplifier warm-up gate for a stereo equalizer.
// Define EQ_MIX_SAT_EN to clamp the mix to DW bits and flag clipping; otherwise the mix wraps.
module eq_mix_core #(
   parameter int NUM_BANDS = 5,
   parameter int DW        = 16,
   parameter int PW        = 12,
   parameter int WARMUP    = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    smpl_vld,
   input  logic [NUM_BANDS*DW-1:0] band_L,
   input  logic [NUM_BANDS*DW-1:0] band_R,
   input  logic [NUM_BANDS*PW-1:0] pot_band,
   input  logic [PW-1:0]           pot_vol,
   input  logic                    seq_ok,
   output logic [DW-1:0]           lft_out,
   output logic [DW-1:0]           rht_out,
   output logic                    out_vld,
   output logic                    busy,
   output logic                    overrun,
   output logic                    sat,
   output logic                    AMP_ON
);

   localparam int IW  = $clog2(NUM_BANDS);
   localparam int AW  = DW + PW + $clog2(NUM_BANDS) + 1;
   localparam int PRW = DW + PW + 1;
   localparam int CW  = $clog2(WARMUP + 1);

   typedef enum logic [1:0] {IDLE, MAC, VOL} state_t;

   state_t                    state;
   logic [IW-1:0]             idx;
   logic [NUM_BANDS*DW-1:0]   bl_r, br_r;
   logic [NUM_BANDS*PW-1:0]   pb_r;
   logic [PW-1:0]             pv_r;
   logic signed [AW-1:0]      acc_l, acc_r;
   logic                      mix_done;
   logic [CW-1:0]             warm_cnt;

   logic signed [DW-1:0]      smp_l, smp_r;
   logic [PW-1:0]             pot_sel;
   logic signed [PRW-1:0]     prod_l, prod_r;
   logic signed [DW-1:0]      red_l, red_r;
   logic signed [PRW-1:0]     vol_l, vol_r;

`ifdef EQ_MIX_SAT_EN
   localparam logic signed [AW-1:0] ACC_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   logic sat_r;
   logic clip;
   assign clip = (acc_l > ACC_MAX) || (acc_l < ACC_MIN) ||
                 (acc_r > ACC_MAX) || (acc_r < ACC_MIN);
   assign sat  = sat_r;
`else
   assign sat = 1'b0;
`endif

   function automatic logic signed [DW-1:0] reduce(input logic signed [AW-1:0] a);
`ifdef EQ_MIX_SAT_EN
      if (a > ACC_MAX)      reduce = {1'b0, {(DW-1){1'b1}}};
      else if (a < ACC_MIN) reduce = {1'b1, {(DW-1){1'b0}}};
      else                  reduce = a[DW-1:0];
`else
      reduce = a[DW-1:0];
`endif
   endfunction

   // One multiplier per channel, fed by the band selected by idx.
   assign smp_l   = bl_r[idx*DW +: DW];
   assign smp_r   = br_r[idx*DW +: DW];
   assign pot_sel = pb_r[idx*PW +: PW];
   assign prod_l  = smp_l * $signed({1'b0, pot_sel});
   assign prod_r  = smp_r * $signed({1'b0, pot_sel});

   // Accumulators and pv_r stay untouched after VOL, so the volume stage reads them one cycle later.
   assign red_l = reduce(acc_l);
   assign red_r = reduce(acc_r);
   assign vol_l = red_l * $signed({1'b0, pv_r});
   assign vol_r = red_r * $signed({1'b0, pv_r});

   assign busy   = (state != IDLE);
   assign AMP_ON = (warm_cnt == CW'(WARMUP));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         bl_r     <= '0;
         br_r     <= '0;
         pb_r     <= '0;
         pv_r     <= '0;
         acc_l    <= '0;
         acc_r    <= '0;
         mix_done <= 1'b0;
         lft_out  <= '0;
         rht_out  <= '0;
         out_vld  <= 1'b0;
         overrun  <= 1'b0;
         warm_cnt <= '0;
`ifdef EQ_MIX_SAT_EN
         sat_r    <= 1'b0;
`endif
      end else begin
         mix_done <= 1'b0;
         out_vld  <= mix_done;
         if (mix_done) begin
            lft_out <= DW'(vol_l >>> PW);
            rht_out <= DW'(vol_r >>> PW);
         end

         if (!seq_ok)
            warm_cnt <= '0;
         else if (smpl_vld && state == IDLE && warm_cnt != CW'(WARMUP))
            warm_cnt <= warm_cnt + 1'b1;

         if (smpl_vld && state != IDLE)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (smpl_vld) begin
                  bl_r  <= band_L;
                  br_r  <= band_R;
                  pb_r  <= pot_band;
                  pv_r  <= pot_vol;
                  acc_l <= '0;
                  acc_r <= '0;
                  idx   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc_l <= acc_l + AW'(prod_l >>> (PW-1));
               acc_r <= acc_r + AW'(prod_r >>> (PW-1));
               if (idx == IW'(NUM_BANDS-1))
                  state <= VOL;
               else
                  idx <= idx + 1'b1;
            end
            VOL: begin
               mix_done <= 1'b1;
`ifdef EQ_MIX_SAT_EN
               if (clip)
                  sat_r <= 1'b1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eq_mix_core.sv
// tb/tb_eq_mix_core.sv - scoreboard bench for eq_mix_core with a behavioural mix model.
// Honours EQ_MIX_SAT_EN the same way as the design.
module tb_eq_mix_core;
   localparam int NB = 5;
   localparam int DW = 16;
   localparam int PW = 12;
   localparam int WU = 4;
   localparam int LAT = NB + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              smpl_vld = 1'b0;
   logic [NB*DW-1:0]  band_L = '0, band_R = '0;
   logic [NB*PW-1:0]  pot_band = '0;
   logic [PW-1:0]     pot_vol = '0;
   logic              seq_ok = 1'b1;
   logic [DW-1:0]     lft_out, rht_out;
   logic              out_vld, busy, overrun, sat, AMP_ON;

   eq_mix_core #(.NUM_BANDS(NB), .DW(DW), .PW(PW), .WARMUP(WU)) dut (
      .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .band_L(band_L), .band_R(band_R),
      .pot_band(pot_band), .pot_vol(pot_vol), .seq_ok(seq_ok), .lft_out(lft_out),
      .rht_out(rht_out), .out_vld(out_vld), .busy(busy), .overrun(overrun),
      .sat(sat), .AMP_ON(AMP_ON)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            cyc;
      bit            s;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = -100;
   int   warm = 0;
   bit   ovr_exp = 0;
   bit   sat_exp = 0;
   logic [DW-1:0] last_l = '0, last_r = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic longint reduce(input longint a, inout bit c);
      longint w;
`ifdef EQ_MIX_SAT_EN
      longint mx = (longint'(1) <<< (DW-1)) - 1;
      longint mn = -(longint'(1) <<< (DW-1));
      if (a > mx) begin c = 1; return mx; end
      if (a < mn) begin c = 1; return mn; end
      return a;
`else
      w = a % (longint'(1) <<< DW);
      if (w < 0) w += (longint'(1) <<< DW);
      if (w >= (longint'(1) <<< (DW-1))) w -= (longint'(1) <<< DW);
      return w;
`endif
   endfunction

   // Gain is pot/2^(PW-1) per band (floored), volume is pot_vol/2^PW (floored).
   task automatic model(input logic [NB*DW-1:0] bl, input logic [NB*DW-1:0] br,
                        input logic [NB*PW-1:0] pb, input logic [PW-1:0] pv,
                        output logic [DW-1:0] ol, output logic [DW-1:0] orr, output bit c);
      longint al = 0, ar = 0, pot, yl, yr;
      logic signed [DW-1:0] sl, sr;
      c = 0;
      for (int b = 0; b < NB; b++) begin
         sl  = bl[b*DW +: DW];
         sr  = br[b*DW +: DW];
         pot = longint'(pb[b*PW +: PW]);
         al += (longint'(sl) * pot) >>> (PW-1);
         ar += (longint'(sr) * pot) >>> (PW-1);
      end
      yl  = (reduce(al, c) * longint'(pv)) >>> PW;
      yr  = (reduce(ar, c) * longint'(pv)) >>> PW;
      ol  = yl[DW-1:0];
      orr = yr[DW-1:0];
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scramble();
      for (int b = 0; b < NB; b++) begin
         band_L[b*DW +: DW] = DW'($urandom);
         band_R[b*DW +: DW] = DW'($urandom);
         pot_band[b*PW +: PW] = PW'($urandom);
      end
      pot_vol = PW'($urandom);
   endtask

   task automatic send(input logic [NB*DW-1:0] bl, input logic [NB*DW-1:0] br,
                       input logic [NB*PW-1:0] pb, input logic [PW-1:0] pv, input bit sq);
      int   e;
      bit   acc, c;
      exp_t x;
      logic [DW-1:0] ol, orr;
      @(negedge clk);
      band_L = bl; band_R = br; pot_band = pb; pot_vol = pv; seq_ok = sq; smpl_vld = 1'b1;
      e   = cyc + 1;
      acc = (e - last_acc) >= LAT;
      if (acc) begin
         last_acc = e;
         model(bl, br, pb, pv, ol, orr, c);
         sat_exp = sat_exp | c;
         x.l = ol; x.r = orr; x.cyc = e + LAT; x.s = sat_exp;
         sbq.push_back(x);
         warm = sq ? ((warm < WU) ? warm + 1 : warm) : 0;
      end else begin
         ovr_exp = 1;
         if (!sq) warm = 0;
      end
      @(negedge clk);
      smpl_vld = 1'b0;
      scramble();
      chk("amp_on", AMP_ON, (warm == WU));
      chk("overrun", overrun, ovr_exp);
      if (acc) chk("busy_after_accept", busy, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; smpl_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      last_acc = -100; warm = 0; ovr_exp = 0; sat_exp = 0;
      chk("rst_lft", lft_out, 0);
      chk("rst_rht", rht_out, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_sat", sat, 0);
      chk("rst_amp_on", AMP_ON, 0);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (rst) begin
         last_l = '0; last_r = '0;
      end else if (out_vld) begin
         if (sbq.size() == 0) begin
            chk("unexpected_out_vld", 1, 0);
         end else begin
            x = sbq.pop_front();
            chk("lft_out", lft_out, x.l);
            chk("rht_out", rht_out, x.r);
            chk("latency", cyc, x.cyc);
            chk("sat_flag", sat, x.s);
         end
         last_l = lft_out; last_r = rht_out;
      end else begin
         chk("hold_lft", lft_out, last_l);
         chk("hold_rht", rht_out, last_r);
      end
   end

   logic [NB*DW-1:0] zb, tb_l;
   logic [NB*PW-1:0] up, tp;

   initial begin
      zb = '0;
      up = {NB{12'h800}};
      do_reset();

      send({NB{16'h0100}}, {NB{16'h0100}}, up, 12'h800, 1);
      idle(10);
      chk("unity_lft", lft_out, 16'h0280);
      chk("unity_rht", rht_out, 16'h0280);

      tb_l = zb; tb_l[2*DW +: DW] = 16'h7FFF;
      tp = up;   tp[2*PW +: PW] = '0;
      send(tb_l, tb_l, tp, 12'h800, 1);
      idle(10);
      chk("zero_pot_lft", lft_out, 0);
      chk("zero_pot_rht", rht_out, 0);

      do_reset();
      send({NB{16'h0123}}, {NB{16'hFF00}}, up, 12'hC00, 1);
      send({NB{16'h7777}}, {NB{16'h1111}}, up, 12'h800, 1);
      idle(12);
      chk("overrun_sticky", overrun, 1);

      send({NB{16'h7000}}, {NB{16'h9000}}, {NB{12'hFFF}}, 12'hFFF, 1);
      idle(10);
`ifdef EQ_MIX_SAT_EN
      chk("clip_lft", lft_out, 16'h7FF7);
      chk("clip_rht", rht_out, 16'h8008);
      chk("clip_sat", sat, 1);
`else
      chk("wrap_sat_tied", sat, 0);
`endif

      do_reset();
      for (int i = 0; i < WU; i++) begin
         send({NB{16'h0040}}, {NB{16'hFFC0}}, up, 12'h800, 1);
         idle(8);
      end
      chk("warm_amp_on", AMP_ON, 1);
      seq_ok = 1'b0;
      warm = 0;
      @(negedge clk);
      chk("warm_amp_off", AMP_ON, 0);
      seq_ok = 1'b1;

      send({NB{16'h0200}}, {NB{16'h0300}}, up, 12'h800, 1);
      idle(1);
      do_reset();
      idle(10);
      chk("abort_lft", lft_out, 0);
      chk("abort_busy", busy, 0);
      send({NB{16'h0100}}, {NB{16'h0100}}, up, 12'h800, 1);
      idle(10);
      chk("after_abort_lft", lft_out, 16'h0280);

      for (int i = 0; i < 150; i++) begin
         for (int b = 0; b < NB; b++) begin
            tb_l[b*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 4095) - 2048);
            tp[b*PW +: PW]   = PW'($urandom);
         end
         send(tb_l, {tb_l[DW-1:0], tb_l[NB*DW-1:DW]}, tp, PW'($urandom),
              $urandom_range(0, 7) != 0);
         idle($urandom_range(0, 9));
      end

      idle(20);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
